// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI master controller: command encodings,
// frame constants and the controller state type.
// No ports (package).
package spi_pkg;

    // Command field, cmd_word[9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Frame constants
    localparam int DATA_BITS = 10;  // command + payload bits shifted out on MOSI
    localparam int RD_BITS   = 8;   // response bits captured from MISO

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CMD     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_TAIL    = 3'd6,
        ST_GAP     = 3'd7
    } spi_state_t;

    // Only read-data frames have a MISO response phase.
    function automatic logic is_rd_data(input logic [1:0] cmd);
        return cmd == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
// Bundles the parallel command port and the serial SPI pins of the master.
//   start, cmd_word : command request from the host
//   busy, done      : frame status
//   rd_data, rd_valid : captured read-data response
//   SS_n, MOSI, MISO  : serial link to the SPI slave
// Modports: slave  = controller side (spi_master_ctrl)
//           master = host/environment side
//
// Handshake: a command is taken on a rising clk edge where start=1 and
// busy=0; start while busy=1 is dropped, nothing is queued. cmd_word only
// needs to be valid on that accepting edge. done (and rd_valid on read-data
// frames) pulses for exactly one cycle when SS_n returns high.
interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] cmd_word;
    logic                 busy;
    logic                 done;
    logic [RD_BITS-1:0]   rd_data;
    logic                 rd_valid;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;

    modport slave (
        input  start, cmd_word, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport master (
        output start, cmd_word, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );

endinterface

// File: rtl/spi_shift_reg.sv
// spi_shift_reg
// Parameterised load / shift-left register. Load wins over shift; the
// serial input enters at bit 0 so the first bit shifted in ends up as MSB.
//   clk, rst  : clock, synchronous active-high reset (clears to 0)
//   load      : parallel load of load_val
//   load_val  : value to load
//   shift_en  : shift left by one, ser_in into bit 0
//   ser_in    : serial input
//   q         : register contents (q[W-1] is the serial output)
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[W-2:0], ser_in};
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI master for the RAM subsystem slave port. Takes a 10-bit command,
// drives one frame on SS_n/MOSI (select cycle, command-check bit, 10 data
// bits MSB first) and, for read-data commands, captures an 8-bit MISO
// response. MOSI/MISO are timed directly on clk.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   bus       : spi_master_ctrl_if.slave (command port + SPI pins)
//   state_dbg : current controller state
// Parameters:
//   RD_WAIT : cycles between last MOSI bit and first MISO sample (>=1)
//   GAP     : minimum SS_n-high cycles between frames (>=1)
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.slave   bus,
    output spi_state_t         state_dbg
);

    // One shared down-counter serves SHIFT, WAIT, CAPTURE and GAP; it is
    // sized for the longest of them.
    localparam int CNT_MAX_A = (RD_WAIT > GAP) ? RD_WAIT : GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > DATA_BITS) ? CNT_MAX_A : DATA_BITS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    spi_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_frame_q;
    logic                 done_q;
    logic                 rd_valid_q;
    logic [RD_BITS-1:0]   rd_data_q;
    logic [DATA_BITS-1:0] mosi_q;
    logic [RD_BITS-1:0]   miso_q;
    logic                 gap_last;
    logic                 capture_last;
    logic                 busy;
    logic                 accept;
    logic                 mosi_active;
    logic                 unused_mosi_tail;

    // The last GAP cycle already counts as not busy so a new start can be
    // taken on the edge that ends the gap; this gives exactly GAP high
    // cycles between frames when start is held.
    assign gap_last     = (state_q == ST_GAP) && (cnt_q == '0);
    assign capture_last = (state_q == ST_CAPTURE) && (cnt_q == '0);
    assign busy         = !((state_q == ST_IDLE) || gap_last);
    assign accept       = bus.start && !busy;

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                state_d = ST_CMD;
            end
            ST_CMD: begin
                state_d = ST_SHIFT;
                cnt_d   = CNT_W'(DATA_BITS - 1);
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    if (rd_frame_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                    end else begin
                        state_d = ST_TAIL;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = CNT_W'(RD_BITS - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TAIL: begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(GAP - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = accept ? ST_SELECT : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_frame_q <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= (state_q == ST_TAIL) || capture_last;
            rd_valid_q <= capture_last;
            if (accept) begin
                rd_frame_q <= is_rd_data(bus.cmd_word[DATA_BITS-1:DATA_BITS-2]);
            end
            if (capture_last) begin
                rd_data_q <= miso_q;
            end
        end
    end

    // MOSI source: the whole command is loaded on acceptance, so later
    // cmd_word changes cannot reach the wire. It only moves during SHIFT;
    // SELECT and CMD both present the MSB.
    spi_shift_reg #(
        .W (DATA_BITS)
    ) u_mosi_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.cmd_word),
        .shift_en (state_q == ST_SHIFT),
        .ser_in   (1'b0),
        .q        (mosi_q)
    );

    // MISO capture: sample on every edge that enters or stays in CAPTURE,
    // i.e. the first sample lands on the edge that ends WAIT. Cleared on
    // acceptance so no stale bits survive from a previous frame.
    spi_shift_reg #(
        .W (RD_BITS)
    ) u_miso_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .shift_en (state_d == ST_CAPTURE),
        .ser_in   (bus.MISO),
        .q        (miso_q)
    );

    assign mosi_active      = (state_q == ST_SELECT) || (state_q == ST_CMD) ||
                              (state_q == ST_SHIFT);
    assign unused_mosi_tail = ^mosi_q[DATA_BITS-2:0];

    assign bus.SS_n     = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign bus.MOSI     = mosi_active ? mosi_q[DATA_BITS-1] : 1'b0;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl (RD_WAIT=2, GAP=1). Inputs are driven
// 1 ns after each rising edge; outputs are recorded at that same point,
// so record index e holds the state after edge t+e of a frame.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    spi_state_t state_dbg;
    int         checks   = 0;
    int         failures = 0;
    int         idx      = 0;

    logic       ss_rec   [0:127];
    logic       mosi_rec [0:127];
    logic       done_rec [0:127];
    logic       rdv_rec  [0:127];
    logic       busy_rec [0:127];
    logic [7:0] rd_rec   [0:127];

    logic [9:0] held_cmd [0:3];
    int         held_f0  [0:3];
    logic [9:0] cmd;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(
        .RD_WAIT (2),
        .GAP     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and record the outputs
    task automatic step();
        @(posedge clk);
        #1;
        if (idx < 128) begin
            ss_rec[idx]   = bus.SS_n;
            mosi_rec[idx] = bus.MOSI;
            done_rec[idx] = bus.done;
            rdv_rec[idx]  = bus.rd_valid;
            busy_rec[idx] = bus.busy;
            rd_rec[idx]   = bus.rd_data;
            idx++;
        end
    endtask

    // Slave response: bit for the edge t+e, MSB first from edge t+14
    function automatic logic miso_bit(input int e, input logic [7:0] b);
        if (e >= 14 && e <= 21) return b[21-e];
        return 1'b0;
    endfunction

    // Expected MOSI after edge t+e: select and command-check carry cmd[9],
    // then bits 9..0, then idle low
    function automatic logic exp_mosi(input logic [9:0] c, input int e);
        if (e <= 1) return c[9];
        if (e <= 11) return c[11-e];
        return 1'b0;
    endfunction

    // Check one whole frame recorded from index f0 (edge t) to its done edge
    task automatic check_frame(input string name, input logic [9:0] c, input int f0,
                               input logic [7:0] rd_before, input logic [7:0] rd_after);
        logic is_rd;
        int   len;
        is_rd = (c[9:8] == CMD_RD_DATA);
        len   = is_rd ? 22 : 13;
        for (int e = 0; e <= len; e++) begin
            check($sformatf("%s_ss_e%0d", name, e),   32'(ss_rec[f0+e]),   32'(e == len));
            check($sformatf("%s_mosi_e%0d", name, e), 32'(mosi_rec[f0+e]), 32'(exp_mosi(c, e)));
            check($sformatf("%s_done_e%0d", name, e), 32'(done_rec[f0+e]), 32'(e == len));
            check($sformatf("%s_rdv_e%0d", name, e),  32'(rdv_rec[f0+e]),  32'(is_rd && e == len));
            check($sformatf("%s_busy_e%0d", name, e), 32'(busy_rec[f0+e]), 32'(e != len));
            check($sformatf("%s_rd_e%0d", name, e),   32'(rd_rec[f0+e]),
                  32'((e == len) ? rd_after : rd_before));
        end
    endtask

    initial begin
        // ---- reset ----
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.cmd_word = '0;
        bus.MISO     = 1'b0;
        step();
        step();
        check("rst_ss",    32'(bus.SS_n),     32'd1);
        check("rst_mosi",  32'(bus.MOSI),     32'd0);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_done",  32'(bus.done),     32'd0);
        check("rst_rdv",   32'(bus.rd_valid), 32'd0);
        check("rst_rd",    32'(bus.rd_data),  32'd0);
        check("rst_state", 32'(state_dbg),    32'(ST_IDLE));
        rst = 1'b0;
        step();

        // ---- write address; cmd_word scrambled after acceptance ----
        idx          = 0;
        cmd          = 10'b00_1010_0101;
        bus.start    = 1'b1;
        bus.cmd_word = cmd;
        step();
        bus.start    = 1'b0;
        bus.cmd_word = 10'h3FF;
        for (int e = 1; e <= 13; e++) begin
            bus.MISO = 1'($urandom_range(0, 1));
            step();
        end
        check_frame("wr_addr", cmd, 0, 8'h00, 8'h00);

        // ---- read data, slave returns C3; back-to-back at t+14 ----
        idx          = 0;
        cmd          = 10'b11_0000_0000;
        bus.start    = 1'b1;
        bus.cmd_word = cmd;
        step();
        bus.start    = 1'b0;
        bus.cmd_word = 10'h0AA;
        for (int e = 1; e <= 22; e++) begin
            bus.MISO = miso_bit(e, 8'hC3);
            step();
        end
        check_frame("rd_data", cmd, 0, 8'h00, 8'hC3);

        // ---- start while busy (pulse at t+5) is ignored ----
        idx          = 0;
        cmd          = 10'b01_0110_1001;
        bus.start    = 1'b1;
        bus.cmd_word = cmd;
        step();
        bus.start    = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            bus.MISO = 1'b0;
            if (e == 5) begin
                bus.start    = 1'b1;
                bus.cmd_word = 10'b11_1111_1111;
            end
            step();
            bus.start = 1'b0;
        end
        check_frame("busy_start", cmd, 0, 8'hC3, 8'hC3);
        for (int e = 14; e <= 16; e++) begin
            check($sformatf("busy_start_idle_ss_e%0d", e),   32'(ss_rec[e]),   32'd1);
            check($sformatf("busy_start_idle_busy_e%0d", e), 32'(busy_rec[e]), 32'd0);
            check($sformatf("busy_start_idle_done_e%0d", e), 32'(done_rec[e]), 32'd0);
        end

        // ---- reset at t+6 during a read-data frame ----
        idx          = 0;
        cmd          = 10'b11_1100_0011;
        bus.start    = 1'b1;
        bus.cmd_word = cmd;
        step();
        bus.start    = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            bus.MISO = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        for (int e = 7; e <= 10; e++) begin
            step();
        end
        for (int e = 6; e <= 10; e++) begin
            check($sformatf("mid_rst_ss_e%0d", e),   32'(ss_rec[e]),   32'd1);
            check($sformatf("mid_rst_mosi_e%0d", e), 32'(mosi_rec[e]), 32'd0);
            check($sformatf("mid_rst_busy_e%0d", e), 32'(busy_rec[e]), 32'd0);
            check($sformatf("mid_rst_rd_e%0d", e),   32'(rd_rec[e]),   32'd0);
        end
        for (int e = 0; e <= 10; e++) begin
            check($sformatf("mid_rst_done_e%0d", e), 32'(done_rec[e]), 32'd0);
            check($sformatf("mid_rst_rdv_e%0d", e),  32'(rdv_rec[e]),  32'd0);
        end

        // ---- frame after reset is correct ----
        idx          = 0;
        cmd          = 10'b11_1111_0000;
        bus.start    = 1'b1;
        bus.cmd_word = cmd;
        step();
        bus.start    = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            bus.MISO = miso_bit(e, 8'h5A);
            step();
        end
        check_frame("post_rst", cmd, 0, 8'h00, 8'h5A);

        // ---- four frames with start held high ----
        held_cmd[0] = 10'b00_0001_0010;
        held_cmd[1] = 10'b01_1000_0001;
        held_cmd[2] = 10'b10_0111_1110;
        held_cmd[3] = 10'b11_0101_0101;
        held_f0[0]  = 0;
        held_f0[1]  = 14;
        held_f0[2]  = 28;
        held_f0[3]  = 42;
        idx         = 0;
        bus.start   = 1'b1;
        for (int g = 0; g <= 66; g++) begin
            bus.cmd_word = 10'($urandom_range(0, 1023));
            for (int k = 0; k < 4; k++) begin
                if (g == held_f0[k]) bus.cmd_word = held_cmd[k];
            end
            bus.MISO = (g >= 42) ? miso_bit(g - 42, 8'h96) : 1'b0;
            if (g == 65) bus.start = 1'b0;
            step();
        end
        check_frame("held0", held_cmd[0], held_f0[0], 8'h5A, 8'h5A);
        check_frame("held1", held_cmd[1], held_f0[1], 8'h5A, 8'h5A);
        check_frame("held2", held_cmd[2], held_f0[2], 8'h5A, 8'h5A);
        check_frame("held3", held_cmd[3], held_f0[3], 8'h5A, 8'h96);
        for (int g = 65; g <= 66; g++) begin
            check($sformatf("held_end_ss_g%0d", g),   32'(ss_rec[g]),   32'd1);
            check($sformatf("held_end_busy_g%0d", g), 32'(busy_rec[g]), 32'd0);
            check($sformatf("held_end_rd_g%0d", g),   32'(rd_rec[g]),   32'h96);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
